// File: rtl/key_schedule_ctrl_pkg.sv
// Shared types and helper functions for the AES key-schedule engine:
// S-box, word rotate, GF(2^8) doubling, FSM encoding and store geometry.
package key_schedule_ctrl_pkg;

   localparam int NB = 4;
   localparam int NR = 14;
   localparam int NW = NB * (NR + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      READY  = 2'd2
   } ks_state_e;

   // Entry k of the table sits at index k; row-major, 16 bytes per line.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] subbytef(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {subbytef(w[31:24]), subbytef(w[23:16]),
              subbytef(w[15:8]),  subbytef(w[7:0])};
   endfunction

   function automatic logic [31:0] rotword(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/key_schedule_ctrl_rk_arbiter.sv
// Round-robin arbiter for the shared round-key read port: one-hot grant,
// ties go to the requester that was not granted most recently.
module rk_arbiter (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic req_enc,
   input  logic req_dec,
   output logic grant_enc,
   output logic grant_dec
);

   logic last_owner;

   // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned and a latch is inferred.
   always_comb begin
      grant_enc = 1'b0;
      grant_dec = 1'b0;
      if (en) begin
         if (req_enc && req_dec) begin
            grant_enc = last_owner;
            grant_dec = !last_owner;
         end else begin
            grant_enc = req_enc;
            grant_dec = req_dec;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_owner <= 1'b1;
      end else if (grant_enc || grant_dec) begin
         last_owner <= grant_dec;
      end
   end

endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES key expansion (one word per cycle) into a register store,
// followed by arbitrated, registered round-key reads for encrypt and decrypt.
module key_schedule_ctrl
   import key_schedule_ctrl_pkg::*;
#(
   parameter int nk = 8,
   parameter int nb = NB,
   parameter int nr = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [32*nk-1:0]  key_in,
   input  logic              key_load,
   output logic              busy,
   output logic              keys_ready,
   input  logic              req_enc,
   input  logic              req_dec,
   input  logic [3:0]        enc_round,
   input  logic [3:0]        dec_round,
   output logic              grant_enc,
   output logic              grant_dec,
   output logic              rk_valid,
   output logic              rk_owner,
   output logic              round_err,
   output logic [127:0]      round_key
);

   localparam int IW = $clog2(NW + 1);
   localparam int nw = nb * (nr + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(nw - 1);
   localparam logic [IW-1:0] NK_IDX   = IW'(nk);
   localparam logic [2:0]    PH_LAST  = 3'(nk - 1);
   localparam logic [3:0]    NR_IDX   = 4'(nr);

   ks_state_e      state, state_next;
   logic [31:0]    w [NW];
   logic [IW-1:0]  widx;
   logic [2:0]     phase;
   logic [7:0]     rcon;
   logic [31:0]    prev_word, old_word, t_word, new_word;

   logic           grant_any, idx_bad;
   logic [3:0]     gidx, rsel;
   logic [IW-1:0]  base;
   logic [127:0]   slice;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (key_load) begin
         state_next = EXPAND;
      end else begin
         case (state)
            IDLE:    state_next = IDLE;
            EXPAND:  if (widx == LAST_IDX) state_next = READY;
            READY:   state_next = READY;
            default: state_next = IDLE;
         endcase
      end
   end

   assign busy       = (state == EXPAND);
   assign keys_ready = (state == READY);

   // phase tracks i mod nk so no divider is needed on the word index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         widx  <= '0;
         phase <= '0;
         rcon  <= 8'h01;
      end else if (key_load) begin
         widx  <= NK_IDX;
         phase <= '0;
         rcon  <= 8'h01;
      end else if (state == EXPAND) begin
         widx  <= widx + 1'b1;
         phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
         if (phase == '0) rcon <= xtime(rcon);
      end
   end

   always_comb begin
      prev_word = w[widx - 1'b1];
      old_word  = w[widx - NK_IDX];
      if (phase == '0)
         t_word = subword(rotword(prev_word)) ^ {rcon, 24'h0};
      else if (nk == 8 && phase == 3'd4)
         t_word = subword(prev_word);
      else
         t_word = prev_word;
      new_word = old_word ^ t_word;
   end

   // NOTE: the word store has no reset; its contents are only readable after a full expansion rewrites them.
   always_ff @(posedge clk) begin
      if (key_load) begin
         for (int k = 0; k < nk; k++) w[k] <= key_in[32*(nk-k)-1 -: 32];
      end else if (state == EXPAND) begin
         w[widx] <= new_word;
      end
   end

   rk_arbiter u_arb (
      .clk       (clk),
      .reset     (reset),
      .en        ((state == READY) && !key_load),
      .req_enc   (req_enc),
      .req_dec   (req_dec),
      .grant_enc (grant_enc),
      .grant_dec (grant_dec)
   );

   assign grant_any = grant_enc | grant_dec;
   assign gidx      = grant_dec ? dec_round : enc_round;
   assign idx_bad   = (gidx > NR_IDX);
   assign rsel      = idx_bad ? 4'd0 : gidx;
   assign base      = IW'({rsel, 2'b00});
   assign slice     = {w[base], w[base + IW'(1)], w[base + IW'(2)], w[base + IW'(3)]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rk_valid  <= 1'b0;
         rk_owner  <= 1'b0;
         round_err <= 1'b0;
         round_key <= '0;
      end else begin
         rk_valid  <= grant_any;
         round_err <= grant_any & idx_bad;
         if (grant_any) begin
            rk_owner  <= grant_dec;
            round_key <= idx_bad ? '0 : slice;
         end
      end
   end

endmodule
